neureka_streamout_filter: RTL and testbench

Sits directly downstream of the engine's `store_out` stream and upstream of the output memory streamer. It consumes the serialized per-PE output words, one word per PE per tile. It drops words belonging to spatially out-of-bounds PEs and trims byte strobes for a partial output-channel block. It counts PEs and tiles, and raises `done_o` once the programmed number of tiles has fully drained. A 2-entry registered output FIFO decouples the engine from memory back-pressure.

---
 rtl/neureka_streamout_filter_if.sv | 13 +
 rtl/neureka_streamout_filter.sv | 181 ++++++++++++++++++
 tb/tb_neureka_streamout_filter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neureka_streamout_filter_if.sv
// Word stream between the engine, the output filter and the memory streamer.
// A word moves on a clock edge where valid and ready are both high.
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                    valid;
   logic                    ready;
   logic [DATA_WIDTH-1:0]   data;
   logic [DATA_WIDTH/8-1:0] strb;

   modport source (output valid, output data, output strb, input ready);
   modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/neureka_streamout_filter.sv
// Drops out-of-bounds PE words, trims channel byte strobes and counts tiles of the
// engine's store stream; a 2-entry registered FIFO decouples it from the streamer.
module neureka_streamout_filter #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned NR_PE      = 36,
   parameter int unsigned TILE_CNT_W = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            enable_i,
   input  logic                            clear_i,
   input  logic                            start_i,
   input  logic [NR_PE-1:0]                pe_mask_i,
   input  logic [TILE_CNT_W-1:0]           nb_tiles_i,
   input  logic [$clog2(DATA_WIDTH/8):0]   ch_bytes_i,
   hwpe_stream_intf_stream.sink            push_i,
   hwpe_stream_intf_stream.source          pop_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic [TILE_CNT_W-1:0]           tile_cnt_o,
   output logic [1:0]                      dbg_state_o
);
   // Both streams: a word transfers on a rising edge with valid & ready high; a source
   // never withdraws valid or changes data/strb before that edge, ready never feeds back
   // combinationally into valid.
   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned CH_W   = $clog2(STRB_W) + 1;
   localparam int unsigned PE_W   = (NR_PE > 1) ? $clog2(NR_PE) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [NR_PE-1:0]      pe_mask_q;
   logic [TILE_CNT_W-1:0] nb_tiles_q, tile_cnt_q, tile_inc;
   logic [CH_W-1:0]       ch_bytes_q;
   logic [PE_W-1:0]       pe_idx_q;
   logic                  done_q, done_d;

   logic [DATA_WIDTH-1:0] head_data_q, tail_data_q;
   logic [STRB_W-1:0]     head_strb_q, tail_strb_q, byte_mask, in_strb;
   logic [1:0]            fifo_cnt_q;
   logic                  fifo_full, fifo_empty, fwd, last_pe;
   logic                  push_hs, fifo_push, fifo_pop;

   assign fifo_full  = (fifo_cnt_q == 2'd2);
   assign fifo_empty = (fifo_cnt_q == 2'd0);
   assign fwd        = pe_mask_q[pe_idx_q];
   assign last_pe    = (pe_idx_q == PE_W'(NR_PE - 1));
   assign tile_inc   = tile_cnt_q + TILE_CNT_W'(1);

   // Dropped words only wait on enable; forwarded ones also on the registered full flag.
   assign push_i.ready = (state_q == RUN) & enable_i & ~clear_i & (~fwd | ~fifo_full);
   assign push_hs      = push_i.valid & push_i.ready;
   assign fifo_push    = push_hs & fwd;
   assign fifo_pop     = pop_o.valid & pop_o.ready;

   always_comb begin
      byte_mask = '0;
      for (int i = 0; i < STRB_W; i++) begin
         byte_mask[i] = (ch_bytes_q == '0) || (CH_W'(i) < ch_bytes_q);
      end
   end

   assign in_strb = push_i.strb & byte_mask;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) state_d = (nb_tiles_i == '0) ? DRAIN : RUN;
         end
         RUN: begin
            if (push_hs && last_pe && (tile_inc == nb_tiles_q)) state_d = DRAIN;
         end
         DRAIN: begin
            // done is registered, so DRAIN lasts one extra cycle while it is shown
            if (done_q)          state_d = IDLE;
            else if (fifo_empty) done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (clear_i) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         done_q     <= 1'b0;
         pe_mask_q  <= '0;
         nb_tiles_q <= '0;
         ch_bytes_q <= '0;
         pe_idx_q   <= '0;
         tile_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         if (clear_i) begin
            pe_idx_q   <= '0;
            tile_cnt_q <= '0;
         end else if ((state_q == IDLE) && start_i) begin
            pe_mask_q  <= pe_mask_i;
            nb_tiles_q <= nb_tiles_i;
            ch_bytes_q <= ch_bytes_i;
            pe_idx_q   <= '0;
            tile_cnt_q <= '0;
         end else if (push_hs) begin
            if (last_pe) begin
               pe_idx_q   <= '0;
               tile_cnt_q <= tile_inc;
            end else begin
               pe_idx_q <= pe_idx_q + PE_W'(1);
            end
         end
      end
   end

   // Head slot drives the output directly; pops are not gated by enable so a
   // transferred word is never presented twice.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_cnt_q  <= 2'd0;
         head_data_q <= '0;
         head_strb_q <= '0;
         tail_data_q <= '0;
         tail_strb_q <= '0;
      end else if (clear_i) begin
         fifo_cnt_q  <= 2'd0;
         head_data_q <= '0;
         head_strb_q <= '0;
         tail_data_q <= '0;
         tail_strb_q <= '0;
      end else begin
         case (fifo_cnt_q)
            2'd0: begin
               if (fifo_push) begin
                  head_data_q <= push_i.data;
                  head_strb_q <= in_strb;
                  fifo_cnt_q  <= 2'd1;
               end
            end
            2'd1: begin
               if (fifo_push && fifo_pop) begin
                  head_data_q <= push_i.data;
                  head_strb_q <= in_strb;
               end else if (fifo_push) begin
                  tail_data_q <= push_i.data;
                  tail_strb_q <= in_strb;
                  fifo_cnt_q  <= 2'd2;
               end else if (fifo_pop) begin
                  fifo_cnt_q <= 2'd0;
               end
            end
            default: begin
               if (fifo_pop) begin
                  head_data_q <= tail_data_q;
                  head_strb_q <= tail_strb_q;
                  fifo_cnt_q  <= 2'd1;
               end
            end
         endcase
      end
   end

   assign pop_o.valid = ~fifo_empty;
   assign pop_o.data  = head_data_q;
   assign pop_o.strb  = head_strb_q;

   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;
   assign tile_cnt_o  = tile_cnt_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_neureka_streamout_filter.sv
// Directed bench for neureka_streamout_filter: table of jobs plus hand sequences for
// empty jobs, back-pressure, clear and asynchronous reset.
`timescale 1ns/1ps
module tb_neureka_streamout_filter;
   localparam int DW  = 256;
   localparam int NPE = 36;
   localparam int TW  = 16;
   localparam int SW  = DW / 8;
   localparam int CBW = $clog2(SW) + 1;

   typedef struct {
      logic [NPE-1:0] mask;
      int             tiles;
      int             chb;
      logic [SW-1:0]  in_strb;
      logic [SW-1:0]  exp_strb;
      int             exp_words;
   } vec_t;

   vec_t vecs[8];

   logic           clk      = 1'b0;
   logic           rst_n    = 1'b0;
   logic           enable   = 1'b0;
   logic           clear    = 1'b0;
   logic           start    = 1'b0;
   logic [NPE-1:0] pe_mask  = '0;
   logic [TW-1:0]  nb_tiles = '0;
   logic [CBW-1:0] ch_bytes = '0;
   logic           busy, done;
   logic [TW-1:0]  tile_cnt;
   logic [1:0]     dbg_state;

   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop ();

   logic [DW-1:0] exp_q[$];
   logic [SW-1:0] exp_s[$];
   int n_vec = 0, n_err = 0, pop_cnt = 0, done_cnt = 0, acc_cnt = 0, job_id = 0;

   neureka_streamout_filter #(.DATA_WIDTH(DW), .NR_PE(NPE), .TILE_CNT_W(TW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear), .start_i(start),
      .pe_mask_i(pe_mask), .nb_tiles_i(nb_tiles), .ch_bytes_i(ch_bytes),
      .push_i(push), .pop_o(pop), .busy_o(busy), .done_o(done),
      .tile_cnt_o(tile_cnt), .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at 1ms, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- compare helpers ----------------
   task automatic check_bit(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0b required %0b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic check_strb(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic          hold = 1'b0;
   logic [DW-1:0] hold_data = '0;
   logic [SW-1:0] hold_strb = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (hold) begin
            check_bit("hold_valid", pop.valid, 1'b1);
            check_vec("hold_data", pop.data, hold_data);
            check_strb("hold_strb", pop.strb, hold_strb);
         end
         if (pop.valid && pop.ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_pop: got word %h, required none", pop.data);
            end else begin
               check_vec("pop_data", pop.data, exp_q.pop_front());
               check_strb("pop_strb", pop.strb, exp_s.pop_front());
            end
         end
         hold      = pop.valid && !pop.ready && !clear;
         hold_data = pop.data;
         hold_strb = pop.strb;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] mk_word(input int j, input int t, input int p);
      logic [7:0] jb, tb8, pb;
      jb  = j[7:0];
      tb8 = t[7:0];
      pb  = p[7:0];
      return {8{jb, tb8, pb, 8'h5A}};
   endfunction

   task automatic push_word(input logic [DW-1:0] d, input logic [SW-1:0] s, output int stalls);
      logic acc;
      stalls     = 0;
      push.valid = 1'b1;
      push.data  = d;
      push.strb  = s;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         acc = push.ready;
         tick();
         if (acc) begin
            push.valid = 1'b0;
            acc_cnt++;
            return;
         end
         stalls++;
      end
      push.valid = 1'b0;
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: word not accepted in 60 cycles, required acceptance");
   endtask

   task automatic start_job(input logic [NPE-1:0] m, input int tiles, input int chb);
      pe_mask  = m;
      nb_tiles = TW'(tiles);
      ch_bytes = CBW'(chb);
      start    = 1'b1;
      tick();
      start    = 1'b0;
      // configuration must have been latched; scramble the live inputs
      pe_mask  = ~m;
      nb_tiles = TW'(tiles + 7);
      ch_bytes = CBW'(chb) ^ CBW'(3);
   endtask

   task automatic wait_done(input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (done) begin
            tick();
            return;
         end
      end
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles, required a pulse", budget);
   endtask

   task automatic push_tile(input int t, input logic [NPE-1:0] m, input int p_lo, input int p_hi,
                            input logic [SW-1:0] s_in, input logic [SW-1:0] s_exp, output int stalls);
      int st;
      stalls = 0;
      for (int p = p_lo; p <= p_hi; p++) begin
         if (m[p]) begin
            exp_q.push_back(mk_word(job_id, t, p));
            exp_s.push_back(s_exp);
         end
         push_word(mk_word(job_id, t, p), s_in, st);
         stalls += st;
      end
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      int   st, stalls;
      v        = vecs[i];
      job_id++;
      done_cnt = 0;
      pop_cnt  = 0;
      stalls   = 0;
      start_job(v.mask, v.tiles, v.chb);
      check_bit($sformatf("v%0d_busy_start", i), busy, 1'b1);
      for (int t = 0; t < v.tiles; t++) begin
         push_tile(t, v.mask, 0, NPE - 1, v.in_strb, v.exp_strb, st);
         stalls += st;
      end
      wait_done(100);
      repeat (2) tick();
      check_int($sformatf("v%0d_words_out", i), pop_cnt, v.exp_words);
      check_int($sformatf("v%0d_tile_cnt", i), int'(tile_cnt), v.tiles);
      check_int($sformatf("v%0d_done_pulses", i), done_cnt, 1);
      check_int($sformatf("v%0d_stalls", i), stalls, 0);
      check_int($sformatf("v%0d_exp_left", i), exp_q.size(), 0);
      check_bit($sformatf("v%0d_busy_end", i), busy, 1'b0);
   endtask

   // ---------------- test ----------------
   initial begin
      int  st, stalls;
      logic saw_full;

      vecs[0] = '{36'hF_FFFF_FFFF, 2, 0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 72};
      vecs[1] = '{36'h0_0000_003F, 1, 0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6};
      vecs[2] = '{36'hF_FFFF_FFFF, 1, 5,  32'hFFFF_FFFF, 32'h0000_001F, 36};
      vecs[3] = '{36'hF_FFFF_FFFF, 1, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 36};
      vecs[4] = '{36'h0_0000_0000, 1, 0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0};
      vecs[5] = '{36'h5_5555_5555, 1, 3,  32'hF0F0_F0F5, 32'h0000_0005, 18};
      vecs[6] = '{36'h8_0000_0001, 3, 31, 32'hC3FF_FFFF, 32'h43FF_FFFF, 6};
      vecs[7] = '{36'hF_0000_0000, 2, 1,  32'hFFFF_FFFE, 32'h0000_0000, 8};

      push.valid = 1'b0;
      push.data  = '0;
      push.strb  = '0;
      pop.ready  = 1'b1;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check_bit("rst_push_ready", push.ready, 1'b0);
      check_bit("rst_pop_valid", pop.valid, 1'b0);
      check_vec("rst_pop_data", pop.data, '0);
      check_strb("rst_pop_strb", pop.strb, '0);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_done", done, 1'b0);
      check_int("rst_tile_cnt", int'(tile_cnt), 0);
      check_int("rst_state", int'(dbg_state), 0);
      rst_n  = 1'b1;
      enable = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) run_vec(i);

      // empty job: done two cycles after start, nothing accepted
      done_cnt   = 0;
      job_id++;
      push.valid = 1'b1;
      push.data  = mk_word(job_id, 0, 0);
      push.strb  = '1;
      start_job('1, 0, 0);
      @(negedge clk);
      check_bit("t0_busy_c1", busy, 1'b1);
      check_bit("t0_done_c1", done, 1'b0);
      check_bit("t0_ready_c1", push.ready, 1'b0);
      @(negedge clk);
      check_bit("t0_done_c2", done, 1'b1);
      check_bit("t0_ready_c2", push.ready, 1'b0);
      @(negedge clk);
      check_bit("t0_done_c3", done, 1'b0);
      check_bit("t0_busy_c3", busy, 1'b0);
      push.valid = 1'b0;
      tick();
      check_int("t0_done_pulses", done_cnt, 1);
      check_int("t0_tile_cnt", int'(tile_cnt), 0);

      // spatial leftover: drops flow at 1/cycle with pop ready low; enable gates input
      job_id++;
      done_cnt = 0;
      pop_cnt  = 0;
      start_job(36'h0_0000_003F, 1, 0);
      push_tile(0, 36'h0_0000_003F, 0, 5, '1, '1, st);
      pop.ready = 1'b0;
      push_tile(0, 36'h0_0000_003F, 6, 20, '1, '1, stalls);
      enable     = 1'b0;
      push.valid = 1'b1;
      push.data  = mk_word(job_id, 0, 21);
      @(negedge clk);
      check_bit("en_low_ready", push.ready, 1'b0);
      tick();
      enable = 1'b1;
      push_tile(0, 36'h0_0000_003F, 21, NPE - 1, '1, '1, st);
      stalls += st;
      check_int("drop_stalls", stalls, 0);
      check_bit("drop_pop_valid", pop.valid, 1'b1);
      pop.ready = 1'b1;
      wait_done(50);
      repeat (2) tick();
      check_int("sp_words_out", pop_cnt, 6);
      check_int("sp_done_pulses", done_cnt, 1);

      // back-pressure mid-tile
      job_id++;
      done_cnt = 0;
      pop_cnt  = 0;
      saw_full = 1'b0;
      acc_cnt  = 0;
      start_job('1, 1, 0);
      fork
         push_tile(0, '1, 0, NPE - 1, '1, '1, st);
         begin
            wait (acc_cnt >= 8);
            pop.ready = 1'b0;
            repeat (10) begin
               @(negedge clk);
               if (!push.ready && push.valid && pop.valid) saw_full = 1'b1;
            end
            tick();
            pop.ready = 1'b1;
         end
      join
      wait_done(50);
      repeat (2) tick();
      check_bit("bp_saw_full", saw_full, 1'b1);
      check_int("bp_words_out", pop_cnt, 36);
      check_int("bp_done_pulses", done_cnt, 1);
      check_int("bp_exp_left", exp_q.size(), 0);

      // clear in tile 1 with two words held in the FIFO
      job_id++;
      done_cnt = 0;
      start_job(36'hF_FFFF_FF00, 2, 0);
      push_tile(0, 36'hF_FFFF_FF00, 0, NPE - 1, '1, '1, st);
      repeat (3) tick();
      check_int("cl_tile_cnt_pre", int'(tile_cnt), 1);
      pop.ready = 1'b0;
      push_tile(1, 36'hF_FFFF_FF00, 0, 9, '1, '1, st);
      push.valid = 1'b1;
      push.data  = mk_word(job_id, 1, 10);
      repeat (3) @(negedge clk);
      check_bit("cl_full_ready", push.ready, 1'b0);
      check_bit("cl_pop_valid_pre", pop.valid, 1'b1);
      check_int("cl_fifo_words", exp_q.size(), 2);
      tick();
      clear      = 1'b1;
      push.valid = 1'b0;
      tick();
      clear = 1'b0;
      @(negedge clk);
      check_bit("cl_pop_valid", pop.valid, 1'b0);
      check_bit("cl_busy", busy, 1'b0);
      check_int("cl_tile_cnt", int'(tile_cnt), 0);
      check_int("cl_state", int'(dbg_state), 0);
      exp_q.delete();
      exp_s.delete();
      repeat (4) @(negedge clk);
      check_int("cl_no_done", done_cnt, 0);
      tick();
      pop.ready = 1'b1;
      run_vec(0);

      // asynchronous reset while draining
      job_id++;
      start_job('1, 1, 0);
      push_tile(0, '1, 0, 33, '1, '1, st);
      tick();
      pop.ready = 1'b0;
      push_tile(0, '1, 34, 35, '1, '1, st);
      tick();
      check_int("rs_state_drain", int'(dbg_state), 2);
      check_bit("rs_pop_valid_pre", pop.valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_bit("rs_pop_valid", pop.valid, 1'b0);
      check_vec("rs_pop_data", pop.data, '0);
      check_strb("rs_pop_strb", pop.strb, '0);
      check_bit("rs_busy", busy, 1'b0);
      check_bit("rs_done", done, 1'b0);
      check_int("rs_tile_cnt", int'(tile_cnt), 0);
      check_bit("rs_push_ready", push.ready, 1'b0);
      check_int("rs_state", int'(dbg_state), 0);
      exp_q.delete();
      exp_s.delete();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      pop.ready = 1'b1;
      tick();
      run_vec(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
